// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single memory port between instruction fetch (IF)
// and load/store (LS), with at most one transaction outstanding.
// Flow: IDLE grants a requester combinationally and captures its payload.
// ISSUE then holds mem_req until mem_gnt arrives. WAIT then waits for
// mem_rvalid, and the response is returned to the owner one cycle later.
// A cycle counter bounds ISSUE+WAIT; when it hits TIMEOUT the owner receives
// an error response.
// Optional macro ARB_RR_EN: round-robin tie-breaking between IF and LS.
// When it is undefined, LS wins every simultaneous request.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module mem_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      if_req,
   input  logic [`PC_WIDTH-1:0]      if_addr,
   output logic                      if_gnt,
   output logic                      if_rvalid,
   output logic [`INSTR_WIDTH-1:0]   if_rdata,
   output logic                      if_err,
   input  logic                      ls_req,
   input  logic                      ls_we,
   input  logic [31:0]               ls_addr,
   input  logic [31:0]               ls_wdata,
   input  logic [3:0]                ls_wstrb,
   output logic                      ls_gnt,
   output logic                      ls_rvalid,
   output logic [31:0]               ls_rdata,
   output logic                      ls_err,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [31:0]               mem_addr,
   output logic [31:0]               mem_wdata,
   output logic [3:0]                mem_wstrb,
   input  logic                      mem_gnt,
   input  logic                      mem_rvalid,
   input  logic [31:0]               mem_rdata,
   input  logic                      mem_err
);

   localparam int IW = `INSTR_WIDTH;
   localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

   state_t        state_q;
   owner_t        owner_q;
   owner_t        last_owner_q;
   logic [7:0]    cnt_q;
   logic          txn_we_q;

   logic          mem_req_q;
   logic          mem_we_q;
   logic [31:0]   mem_addr_q;
   logic [31:0]   mem_wdata_q;
   logic [3:0]    mem_wstrb_q;

   logic          if_rvalid_q;
   logic [IW-1:0] if_rdata_q;
   logic          if_err_q;
   logic          ls_rvalid_q;
   logic [31:0]   ls_rdata_q;
   logic          ls_err_q;

   logic          ls_pri_d;
   logic          grant_ls_d;
   logic          grant_if_d;
   logic          timeout_d;
   logic          resp_fire_d;
   logic          resp_err_d;
   logic [31:0]   resp_data_d;

   // Arbitration: who wins a tie, and whether a grant is given this cycle
   always_comb begin
`ifdef ARB_RR_EN
      ls_pri_d   = (last_owner_q == OWN_IF);
`else
      ls_pri_d   = 1'b1;
`endif
      grant_ls_d = !rst && (state_q == S_IDLE) && ls_req && (!if_req || ls_pri_d);
      grant_if_d = !rst && (state_q == S_IDLE) && if_req && !grant_ls_d;
   end

   // Response selection: a memory response in WAIT beats a timeout in the same cycle
   always_comb begin
      timeout_d   = (cnt_q == TMO_CNT);
      resp_fire_d = 1'b0;
      resp_err_d  = 1'b0;
      resp_data_d = '0;
      if ((state_q == S_WAIT) && mem_rvalid) begin
         resp_fire_d = 1'b1;
         resp_err_d  = mem_err;
         resp_data_d = txn_we_q ? 32'h0 : mem_rdata;
      end else if (((state_q == S_ISSUE) || (state_q == S_WAIT)) && timeout_d) begin
         resp_fire_d = 1'b1;
         resp_err_d  = 1'b1;
      end
   end

   // Transaction FSM with registered memory-side and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_IF;
         last_owner_q <= OWN_IF;
         cnt_q        <= '0;
         txn_we_q     <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= '0;
         if_rvalid_q  <= 1'b0;
         if_rdata_q   <= '0;
         if_err_q     <= 1'b0;
         ls_rvalid_q  <= 1'b0;
         ls_rdata_q   <= '0;
         ls_err_q     <= 1'b0;
      end else begin
         // Response outputs are single-cycle pulses and are zero otherwise
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         if_err_q    <= 1'b0;
         ls_rvalid_q <= 1'b0;
         ls_rdata_q  <= '0;
         ls_err_q    <= 1'b0;
         if (resp_fire_d) begin
            if (owner_q == OWN_LS) begin
               ls_rvalid_q <= 1'b1;
               ls_rdata_q  <= resp_data_d;
               ls_err_q    <= resp_err_d;
            end else begin
               if_rvalid_q <= 1'b1;
               if_rdata_q  <= resp_data_d[IW-1:0];
               if_err_q    <= resp_err_d;
            end
         end

         case (state_q)
            S_IDLE: begin
               if (grant_ls_d) begin
                  owner_q      <= OWN_LS;
                  last_owner_q <= OWN_LS;
                  txn_we_q     <= ls_we;
                  mem_req_q    <= 1'b1;
                  mem_we_q     <= ls_we;
                  mem_addr_q   <= ls_addr;
                  mem_wdata_q  <= ls_wdata;
                  mem_wstrb_q  <= ls_wstrb;
                  cnt_q        <= '0;
                  state_q      <= S_ISSUE;
               end else if (grant_if_d) begin
                  owner_q      <= OWN_IF;
                  last_owner_q <= OWN_IF;
                  txn_we_q     <= 1'b0;
                  mem_req_q    <= 1'b1;
                  mem_we_q     <= 1'b0;
                  mem_addr_q   <= 32'(if_addr);
                  mem_wdata_q  <= '0;
                  mem_wstrb_q  <= '0;
                  cnt_q        <= '0;
                  state_q      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_q <= cnt_q + 8'd1;
               // Timeout takes precedence over a late acceptance
               if (timeout_d || mem_gnt) begin
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
                  mem_wstrb_q <= '0;
                  state_q     <= timeout_d ? S_IDLE : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q + 8'd1;
               if (resp_fire_d) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign if_gnt    = grant_if_d;
   assign ls_gnt    = grant_ls_d;
   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign if_err    = if_err_q;
   assign ls_rvalid = ls_rvalid_q;
   assign ls_rdata  = ls_rdata_q;
   assign ls_err    = ls_err_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter.
// The arbiter runs against a transaction-level timing model that predicts
// every output on every cycle:
// - grant in cycle 0;
// - mem_req from cycle 1 until mem_gnt or timeout;
// - response one cycle after mem_rvalid or after the timeout.
// Honours ARB_RR_EN when it is defined.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module tb_mem_arbiter;
   localparam int unsigned TIMEOUT = 15;
   localparam int PCW = `PC_WIDTH;
   localparam int IW  = `INSTR_WIDTH;

   logic           clk = 1'b0;
   logic           rst;
   logic           if_req;
   logic [PCW-1:0] if_addr;
   logic           if_gnt;
   logic           if_rvalid;
   logic [IW-1:0]  if_rdata;
   logic           if_err;
   logic           ls_req;
   logic           ls_we;
   logic [31:0]    ls_addr;
   logic [31:0]    ls_wdata;
   logic [3:0]     ls_wstrb;
   logic           ls_gnt;
   logic           ls_rvalid;
   logic [31:0]    ls_rdata;
   logic           ls_err;
   logic           mem_req;
   logic           mem_we;
   logic [31:0]    mem_addr;
   logic [31:0]    mem_wdata;
   logic [3:0]     mem_wstrb;
   logic           mem_gnt;
   logic           mem_rvalid;
   logic [31:0]    mem_rdata;
   logic           mem_err;

   int checks   = 0;
   int failures = 0;
`ifdef ARB_RR_EN
   bit rr_mode = 1'b1;
`else
   bit rr_mode = 1'b0;
`endif

   mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
      .ls_rdata(ls_rdata), .ls_err(ls_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive point: just after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sample point: the falling edge
   task automatic sample();
      @(negedge clk);
   endtask

   task automatic chk_outs(input string tag,
                           input bit e_if_gnt, input bit e_if_rv,
                           input logic [31:0] e_if_rd, input bit e_if_err,
                           input bit e_ls_gnt, input bit e_ls_rv,
                           input logic [31:0] e_ls_rd, input bit e_ls_err,
                           input bit e_mreq, input bit e_we,
                           input logic [31:0] e_addr, input logic [31:0] e_wd,
                           input logic [3:0] e_ws, input bit pay);
      chk({tag, ".if_gnt"},    32'(if_gnt),    32'(e_if_gnt));
      chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(e_if_rv));
      chk({tag, ".if_rdata"},  32'(if_rdata),  e_if_rd);
      chk({tag, ".if_err"},    32'(if_err),    32'(e_if_err));
      chk({tag, ".ls_gnt"},    32'(ls_gnt),    32'(e_ls_gnt));
      chk({tag, ".ls_rvalid"}, 32'(ls_rvalid), 32'(e_ls_rv));
      chk({tag, ".ls_rdata"},  ls_rdata,       e_ls_rd);
      chk({tag, ".ls_err"},    32'(ls_err),    32'(e_ls_err));
      chk({tag, ".mem_req"},   32'(mem_req),   32'(e_mreq));
      if (e_mreq || pay) begin
         chk({tag, ".mem_we"},    32'(mem_we),    32'(e_we));
         chk({tag, ".mem_addr"},  mem_addr,       e_addr);
         chk({tag, ".mem_wdata"}, mem_wdata,      e_wd);
         chk({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'(e_ws));
      end
   endtask

   task automatic quiet();
      if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
   endtask

   task automatic chk_zero(input string tag, input bit pay);
      chk_outs(tag, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, pay);
   endtask

   // Reset is held for two cycles with both requests high; no grant may leak through
   task automatic do_reset();
      rst = 1'b1; if_req = 1'b1; ls_req = 1'b1;
      step();
      sample();
      chk_zero("reset.hold", 1'b1);
      step();
      rst = 1'b0; quiet();
      sample();
      chk_zero("reset.after", 1'b1);
      step();
   endtask

   // Idle cycles with random memory-side noise; nothing may respond
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         quiet();
         mem_gnt    = 1'($urandom);
         mem_rvalid = 1'($urandom);
         mem_err    = 1'($urandom);
         mem_rdata  = $urandom;
         sample();
         chk_zero($sformatf("idle k=%0d", k), 1'b0);
         step();
      end
   endtask

   // One single-requester transaction, judged by the timing model:
   // - grant at k=0;
   // - mem_gnt at k=1+d;
   // - mem_rvalid at k=2+d+r;
   // - response at k=3+d+r unless the counter reaches TIMEOUT first.
   task automatic run_txn(input string nm, input bit ls, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int d, input int r,
                          input bit merr, input logic [31:0] rdata);
      bit tmo, e_err, rv, e_we;
      int rsp_k, mreq_end, to;
      logic [31:0] e_rd, e_if_rd, e_addr, e_wd;
      logic [3:0] e_ws;
      logic [PCW-1:0] pc;
      to       = int'(TIMEOUT);
      tmo      = (d >= to) || (1 + d + r > to);
      rsp_k    = tmo ? to + 2 : 3 + d + r;
      mreq_end = (1 + d < to + 1) ? 1 + d : to + 1;
      e_err    = tmo ? 1'b1 : merr;
      e_rd     = (tmo || (ls && we)) ? 32'h0 : rdata;
      e_if_rd  = 32'(e_rd[IW-1:0]);
      pc       = addr[PCW-1:0];
      e_addr   = ls ? addr : 32'(pc);
      e_we     = ls && we;
      e_wd     = ls ? wdata : 32'h0;
      e_ws     = ls ? wstrb : 4'h0;
      $display("txn %s ls=%0d we=%0d addr=%h d=%0d r=%0d timeout=%0d rsp_cycle=%0d",
               nm, ls, we, addr, d, r, tmo, rsp_k);
      for (int k = 0; k <= rsp_k; k++) begin
         if_req = !ls && (k == 0);
         ls_req = ls && (k == 0);
         if (k == 0) begin
            if_addr = pc; ls_addr = addr; ls_we = we; ls_wdata = wdata; ls_wstrb = wstrb;
         end else begin
            if_addr = PCW'($urandom); ls_addr = $urandom; ls_we = 1'($urandom);
            ls_wdata = $urandom; ls_wstrb = 4'($urandom);
         end
         mem_gnt    = (k == 1 + d);
         mem_rvalid = (k == 2 + d + r) || ((k <= 1 + d) && ($urandom_range(0, 3) == 0));
         mem_rdata  = (k == 2 + d + r) ? rdata : $urandom;
         mem_err    = (k == 2 + d + r) ? merr : 1'($urandom);
         sample();
         rv = (k == rsp_k);
         chk_outs($sformatf("%s k=%0d", nm, k),
                  !ls && (k == 0), !ls && rv, (!ls && rv) ? e_if_rd : 32'h0, !ls && rv && e_err,
                  ls && (k == 0), ls && rv, (ls && rv) ? e_rd : 32'h0, ls && rv && e_err,
                  (k >= 1) && (k <= mreq_end), e_we, e_addr, e_wd, e_ws, 1'b0);
         step();
      end
      quiet();
   endtask

   initial begin
      bit w_ls[4];
      bit last_ls;
      rst = 1'b1;
      quiet();
      if_addr = '0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0; mem_rdata = '0;
      do_reset();

      // Zero-wait fetch: grant at 0, mem_req at 1, rvalid at 3
      run_txn("if_zero_wait", 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 0, 1'b0, 32'h00000013);
      // Store with mem_gnt four cycles late: mem_req held five cycles
      run_txn("ls_store_slow", 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 4, 1, 1'b0, 32'h12345678);

      // Continuous contention for four transactions after a fresh reset
      do_reset();
      last_ls = 1'b0;
      for (int t = 0; t < 4; t++) begin
         w_ls[t] = rr_mode ? !last_ls : 1'b1;
         last_ls = w_ls[t];
      end
      $display("txn contention rr_mode=%0d winners_ls=%0d%0d%0d%0d", rr_mode, w_ls[0], w_ls[1], w_ls[2], w_ls[3]);
      for (int k = 0; k <= 12; k++) begin
         bit g, rv, mr;
         bit gl, rl, ml;
         if_req = (k <= 9); ls_req = (k <= 9);
         if_addr = PCW'(32'h400); ls_addr = 32'h800; ls_we = 1'b0; ls_wdata = '0; ls_wstrb = '0;
         mem_gnt = 1'b1; mem_err = 1'b0;
         mem_rvalid = ((k % 3) == 2) && (k <= 11);
         mem_rdata = 32'hA000 + 32'(k);
         g  = ((k % 3) == 0) && (k <= 9);
         gl = g && w_ls[k / 3 < 4 ? k / 3 : 3];
         rv = ((k % 3) == 0) && (k >= 3);
         rl = rv && w_ls[k >= 3 ? k / 3 - 1 : 0];
         mr = ((k % 3) == 1) && (k <= 10);
         ml = w_ls[k >= 1 ? (k - 1) / 3 : 0];
         sample();
         chk_outs($sformatf("contend k=%0d", k),
                  g && !gl, rv && !rl, (rv && !rl) ? 32'hA000 + 32'(k - 1) : 32'h0, 1'b0,
                  gl, rl, rl ? 32'hA000 + 32'(k - 1) : 32'h0, 1'b0,
                  mr, 1'b0, ml ? 32'h800 : 32'h400, 32'h0, 4'h0, 1'b0);
         step();
      end
      quiet();

      // Memory never answers: error response 16 cycles after ISSUE entry
      run_txn("timeout", 1'b0, 1'b0, 32'h180, 32'h0, 4'h0, 0, 100, 1'b0, 32'h0);
      run_txn("after_timeout", 1'b1, 1'b0, 32'h1C0, 32'h0, 4'h0, 1, 0, 1'b0, 32'hCAFEF00D);

      // Reset while waiting for data; the late response must vanish
      $display("txn reset_in_wait addr=00000300");
      if_req = 1'b1; if_addr = PCW'(32'h300);
      sample();
      chk_outs("rstw k=0", 1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1'b0);
      step();
      if_req = 1'b0; mem_gnt = 1'b1;
      sample();
      chk_outs("rstw k=1", 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h300, 32'h0, 4'h0, 1'b0);
      step();
      mem_gnt = 1'b0;
      sample();
      chk_zero("rstw k=2", 1'b0);
      step();
      rst = 1'b1;
      sample();
      chk_zero("rstw k=3", 1'b0);
      step();
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77; mem_err = 1'b1;
      sample();
      chk_zero("rstw k=4", 1'b1);
      step();
      sample();
      chk_zero("rstw k=5", 1'b1);
      step();
      quiet();
      sample();
      chk_zero("rstw k=6", 1'b1);
      step();
      run_txn("after_reset", 1'b0, 1'b0, 32'h340, 32'h0, 4'h0, 0, 2, 1'b0, 32'h00100073);

      // Memory error on an LS load
      run_txn("ls_mem_err", 1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 1, 2, 1'b1, 32'h55AA55AA);

      // Randomised single-requester traffic
      for (int i = 0; i < 24; i++) begin
         bit rls, rwe, rerr;
         int rd, rr;
         rls  = 1'($urandom_range(0, 1));
         rwe  = rls ? 1'($urandom_range(0, 1)) : 1'b0;
         rd   = (($urandom_range(0, 7)) == 0) ? int'($urandom_range(12, 18)) : int'($urandom_range(0, 5));
         rr   = (($urandom_range(0, 5)) == 0) ? int'($urandom_range(10, 25)) : int'($urandom_range(0, 5));
         rerr = ($urandom_range(0, 7) == 0);
         run_txn($sformatf("rnd%0d", i), rls, rwe, $urandom, $urandom, 4'($urandom),
                 rd, rr, rerr, $urandom);
         idle(int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: response-wait limit in cycles, range 2..255.
REQ-002 Ports, in this order:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  instruction-fetch read request.
- if_addr  in  `PC_WIDTH  fetch address.
- if_gnt  out  1  fetch request accepted.
- if_rvalid  out  1  fetch response valid, one-cycle pulse.
- if_rdata  out  `INSTR_WIDTH  fetch data.
- if_err  out  1  fetch bus error.
- ls_req  in  1  load/store request.
- ls_we  in  1  1 = store.
- ls_addr  in  32  load/store address.
- ls_wdata  in  32  store data.
- ls_wstrb  in  4  byte enables.
- ls_gnt  out  1  load/store request accepted.
- ls_rvalid  out  1  load/store response valid, one-cycle pulse.
- ls_rdata  out  32  load data.
- ls_err  out  1  load/store bus error.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_wstrb  out  4  memory byte enables.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  memory response valid.
- mem_rdata  in  32  memory read data.
- mem_err  in  1  memory error, qualified by mem_rvalid.

Function
REQ-003 The block SHALL share one memory port between IF and LS, with at most one transaction outstanding.
REQ-004 FSM states SHALL be IDLE, ISSUE and WAIT, plus an owner register (IF/LS) and a last_owner register.
REQ-005 IDLE with any req SHALL combinationally assert the winner's gnt in the same cycle, capture its payload (IF: we=0, wstrb=0, wdata=0), set owner, and go to ISSUE.
- The requester SHALL hold req/payload stable until gnt; it may drop req the cycle after gnt.
REQ-006 ISSUE SHALL drive mem_req=1 with the captured payload, hold it until mem_gnt, then go to WAIT.
REQ-007 In WAIT, mem_rvalid SHALL cause, one cycle later, owner rvalid=1 with registered rdata and err, and a return to IDLE.
- A new grant is allowed in that same cycle.
- Zero-wait memory latency: req at cycle 0, rvalid at cycle 3.
REQ-008 A store response SHALL pulse ls_rvalid with ls_rdata=0.
REQ-009 A cycle counter SHALL clear on entry to ISSUE and count in ISSUE and WAIT.
- On reaching TIMEOUT without mem_rvalid: owner rvalid=1, err=1, rdata=0 on the next cycle, then IDLE; mem_req drops.
REQ-010 mem_rvalid outside WAIT SHALL be ignored and produce no rvalid.
REQ-011 The non-owner SHALL never see gnt or rvalid; rdata/err SHALL be 0 whenever rvalid=0.
REQ-012 When only one requester is active it SHALL win regardless of priority; last_owner SHALL update on every grant.

Reset
REQ-013 rst SHALL force state=IDLE, owner=IF, last_owner=IF, counter=0, and all outputs to 0 in the following cycle.
REQ-014 Reset in ISSUE or WAIT SHALL abandon the transaction with no rvalid, and a later mem_rvalid SHALL be ignored.

Configuration
REQ-015 With ARB_RR_EN defined, simultaneous requests SHALL go to the requester that is not last_owner (round-robin).
REQ-016 Without ARB_RR_EN, LS SHALL always win simultaneous requests (fixed priority).
- In both modes LS wins the first tie after reset.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- IF read 0x100, zero-wait memory returning 0x00000013 -> if_gnt at cycle 0, mem_req at cycle 1, if_rvalid with if_rdata=0x00000013 at cycle 3.
- LS store addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF, mem_gnt delayed 4 cycles -> mem_req held 5 cycles with a stable payload, ls_rvalid=1 with ls_rdata=0.
- IF and LS requesting continuously for 4 transactions -> ARB_RR_EN: grants LS,IF,LS,IF; without it: LS,LS,LS,LS.
- mem_rvalid never returned, TIMEOUT=15 -> owner rvalid with err=1 exactly at cycle 16 after ISSUE entry, then IDLE accepts a new request.
- rst asserted during WAIT, then mem_rvalid -> no rvalid, all outputs 0, the next request is served normally.
- mem_err=1 with mem_rvalid on an LS load -> ls_err=1 and ls_rvalid=1 in the same cycle, if_* outputs stay 0.
